arbitro_vc: RTL and testbench
=============================

Name: arbitro_vc

Overview:
- Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the interconnect device.
- Each cycle, grants at most one show-ahead VC FIFO head. Pops it and routes the word to D0 or D1 according to its destination bit.
- Honours downstream almost-full back-pressure and a weight configuration latched on init.

Parameters:
WORD_SIZE, 6, data word width
DEST_BIT, 4, bit of the word selecting destination (0 -> D0, 1 -> D1)
WL, 3, width of weight and credit fields
DEF_W0, 2, VC0 weight after reset
DEF_W1, 1, VC1 weight after reset

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
init  in  1  latch weight_vc0/weight_vc1; restart arbitration
weight_vc0  in  WL  VC0 grants per turn
weight_vc1  in  WL  VC1 grants per turn
vc0_empty  in  1  VC0 FIFO empty
vc1_empty  in  1  VC1 FIFO empty
vc0_data  in  WORD_SIZE  VC0 head word (valid while !vc0_empty)
vc1_data  in  WORD_SIZE  VC1 head word
d0_almost_full  in  1  D0 pause request
d1_almost_full  in  1  D1 pause request
pop_vc0  out  1  combinational pop of VC0 head
pop_vc1  out  1  combinational pop of VC1 head
push_d0  out  1  registered push into D0
push_d1  out  1  registered push into D1
data_out  out  WORD_SIZE  registered word for D0/D1
arb_active  out  1  state is OWN0 or OWN1

Behaviour:
- Reset (synchronous, dominates init):
  - state=IDLE; credit=0; last=VC1, so VC0 wins the first tie.
  - w0=DEF_W0; w1=DEF_W1.
  - Outputs: pop_*, push_*, arb_active = 0; data_out=0 on the next edge.
- Eligibility: eligX = !vcX_empty && !dY_almost_full, where Y = vcX_data[DEST_BIT].
- init high:
  - Latch weights; a weight of 0 is stored as 1.
  - state<=IDLE; credit<=0.
  - pop_* forced 0 that cycle.
  - A push already in flight still completes.
- States: IDLE, OWN0, OWN1.
  - IDLE:
    - Grant the eligible VC.
    - If both are eligible, grant the one != last.
    - Move to OWNx with credit=wX-1.
    - If neither is eligible, stay in IDLE.
  - OWNx with eligX:
    - If credit>0: grant X, credit--.
    - If credit==0 and eligOther: grant other, go to OWNother, credit=wOther-1.
    - If credit==0 and !eligOther: grant X, reload credit=wX-1.
  - OWNx with !eligX:
    - If eligOther: switch immediately (grant other, credit=wOther-1).
    - Otherwise no grant; state and credit hold.
  - OWNx with vc0_empty && vc1_empty: go to IDLE, credit<=0.
- Grant: pop_vcX asserted combinationally in the same cycle. last<=X.
- Latency: one cycle.
  - Next edge: data_out<=granted word; push_d0/push_d1 per DEST_BIT.
  - Exactly one push per pop; never both pushes at once.
  - No grant -> both pushes 0; data_out holds.
- Back-pressure margin:
  - almost_full is sampled at grant time.
  - Destination FIFO thresholds must leave ≥1 free slot for the in-flight word.
- Never pop an empty FIFO. Never pop both FIFOs in one cycle.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt_vc0 and grant_cnt_vc1 (8 bits each), incremented per pop.
  - Counters saturate at 255.
  - Cleared by reset or init.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Weights 2/1 via init; both VCs full; all words DEST=0; no pause -> pop sequence VC0,VC0,VC1,VC0,VC0,VC1...; push_d0 each cycle, one cycle after each pop.
- VC0 head DEST=1 and d1_almost_full=1; VC1 head DEST=0 -> pop_vc0 never asserted; VC1 served every cycle; VC0 resumes the cycle after d1_almost_full drops.
- Both VCs empty from OWN0 -> next cycle IDLE, arb_active=0, no pops or pushes; VC1 becomes non-empty -> pop_vc1 in that cycle, push the following cycle.
- Reset asserted mid-burst (weights 3/3) -> pops 0 in that cycle, pushes and data_out 0 next edge, weights back to 2/1.
- init with weight_vc0=0, weight_vc1=4 -> VC0 is treated as weight 1: pattern VC0,VC1,VC1,VC1,VC1,VC0...
- With ARB_STATS_EN: 300 VC0 grants -> grant_cnt_vc0=255 (saturated); init -> both counters read 0.

Source files
------------

// File: rtl/arbitro_vc.sv
// Weighted round-robin arbiter: pops VC0/VC1 heads into D0/D1.
// Optional ARB_STATS_EN adds saturating per-VC grant counters.
module arbitro_vc #(
   parameter int WORD_SIZE = 6,
   parameter int DEST_BIT  = 4,
   parameter int WL        = 3,
   parameter int DEF_W0    = 2,
   parameter int DEF_W1    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [WL-1:0]        weight_vc0,
   input  logic [WL-1:0]        weight_vc1,
   input  logic                 vc0_empty,
   input  logic                 vc1_empty,
   input  logic [WORD_SIZE-1:0] vc0_data,
   input  logic [WORD_SIZE-1:0] vc1_data,
   input  logic                 d0_almost_full,
   input  logic                 d1_almost_full,
   output logic                 pop_vc0,
   output logic                 pop_vc1,
   output logic                 push_d0,
   output logic                 push_d1,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 arb_active
`ifdef ARB_STATS_EN
   ,
   output logic [7:0]           grant_cnt_vc0,
   output logic [7:0]           grant_cnt_vc1
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [WL-1:0]        credit_q, credit_d;
   logic [WL-1:0]        w0_q, w1_q;
   logic [WL-1:0]        w0m1, w1m1;
   logic                 last_q;
   logic [WORD_SIZE-1:0] data_q;
   logic                 push_d0_q, push_d1_q;
   logic                 elig0, elig1;
   logic                 gnt0, gnt1;

   // Destination pause is judged against the head word's own target
   assign elig0 = !vc0_empty &&
                  !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
   assign elig1 = !vc1_empty &&
                  !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

   assign w0m1 = w0_q - WL'(1);
   assign w1m1 = w1_q - WL'(1);

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (!reset && !init) begin
         case (state_q)
            IDLE: begin
               if (elig0 && (!elig1 || last_q)) begin
                  gnt0     = 1'b1;
                  state_d  = OWN0;
                  credit_d = w0m1;
               end else if (elig1) begin
                  gnt1     = 1'b1;
                  state_d  = OWN1;
                  credit_d = w1m1;
               end
            end
            OWN0: begin
               if (vc0_empty && vc1_empty) begin
                  state_d  = IDLE;
                  credit_d = '0;
               end else if (elig0 && credit_q != '0) begin
                  gnt0     = 1'b1;
                  credit_d = credit_q - WL'(1);
               end else if (elig1) begin
                  gnt1     = 1'b1;
                  state_d  = OWN1;
                  credit_d = w1m1;
               end else if (elig0) begin
                  gnt0     = 1'b1;
                  credit_d = w0m1;
               end
            end
            OWN1: begin
               if (vc0_empty && vc1_empty) begin
                  state_d  = IDLE;
                  credit_d = '0;
               end else if (elig1 && credit_q != '0) begin
                  gnt1     = 1'b1;
                  credit_d = credit_q - WL'(1);
               end else if (elig0) begin
                  gnt0     = 1'b1;
                  state_d  = OWN0;
                  credit_d = w0m1;
               end else if (elig1) begin
                  gnt1     = 1'b1;
                  credit_d = w1m1;
               end
            end
            default: begin
               state_d  = IDLE;
               credit_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         credit_q  <= '0;
         last_q    <= 1'b1;
         w0_q      <= WL'(DEF_W0);
         w1_q      <= WL'(DEF_W1);
         data_q    <= '0;
         push_d0_q <= 1'b0;
         push_d1_q <= 1'b0;
      end else begin
         if (init) begin
            w0_q     <= (weight_vc0 == '0) ? WL'(1) : weight_vc0;
            w1_q     <= (weight_vc1 == '0) ? WL'(1) : weight_vc1;
            state_q  <= IDLE;
            credit_q <= '0;
         end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
         end
         if (gnt0 || gnt1) begin
            last_q <= gnt1;
            data_q <= gnt1 ? vc1_data : vc0_data;
         end
         push_d0_q <= (gnt0 && !vc0_data[DEST_BIT]) ||
                      (gnt1 && !vc1_data[DEST_BIT]);
         push_d1_q <= (gnt0 && vc0_data[DEST_BIT]) ||
                      (gnt1 && vc1_data[DEST_BIT]);
      end
   end

   assign pop_vc0    = gnt0;
   assign pop_vc1    = gnt1;
   assign push_d0    = push_d0_q;
   assign push_d1    = push_d1_q;
   assign data_out   = data_q;
   assign arb_active = (state_q == OWN0) || (state_q == OWN1);

`ifdef ARB_STATS_EN
   logic [7:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk) begin
      if (reset || init) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt0 && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
         if (gnt1 && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
      end
   end

   assign grant_cnt_vc0 = cnt0_q;
   assign grant_cnt_vc1 = cnt1_q;
`endif

endmodule

// File: tb/tb_arbitro_vc.sv
// Bench for arbitro_vc: vector table, corner sequences, random vs model.
// Build with ARB_STATS_EN defined to also cover the grant counters.
module tb_arbitro_vc;

   logic       clk = 1'b0;
   logic       reset, init;
   logic [2:0] weight_vc0, weight_vc1;
   logic       vc0_empty, vc1_empty;
   logic [5:0] vc0_data, vc1_data;
   logic       d0_almost_full, d1_almost_full;
   logic       pop_vc0, pop_vc1, push_d0, push_d1, arb_active;
   logic [5:0] data_out;
`ifdef ARB_STATS_EN
   logic [7:0] grant_cnt_vc0, grant_cnt_vc1;
`endif

   arbitro_vc dut (
      .clk(clk), .reset(reset), .init(init),
      .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_almost_full(d0_almost_full),
      .d1_almost_full(d1_almost_full),
      .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
      .push_d0(push_d0), .push_d1(push_d1),
      .data_out(data_out), .arb_active(arb_active)
`ifdef ARB_STATS_EN
      , .grant_cnt_vc0(grant_cnt_vc0), .grant_cnt_vc1(grant_cnt_vc1)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int obs_g;

   // Model: current owner (-1 none), grants used in its turn, weights
   int m_owner, m_used, m_last, m_data, m_push0, m_push1;
   int m_w[2];
   int m_cnt[2];

   typedef struct {
      bit rst, ini;
      bit [2:0] w0, w1;
      bit em0, em1;
      bit [5:0] dt0, dt1;
      bit af0, af1;
      bit p0, p1, q0, q1, act;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_used = 0; m_last = 1;
      m_w[0] = 2; m_w[1] = 1;
      m_data = 0; m_push0 = 0; m_push1 = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   task automatic drive(bit r, bit i, int w0, int w1, bit e0, bit e1,
                        int d0, int d1, bit a0, bit a1);
      reset = r; init = i;
      weight_vc0 = 3'(w0); weight_vc1 = 3'(w1);
      vc0_empty = e0; vc1_empty = e1;
      vc0_data = 6'(d0); vc1_data = 6'(d1);
      d0_almost_full = a0; d1_almost_full = a1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare DUT with model for this cycle, then advance the model
   task automatic eval();
      int el[2], emp[2], g, x, o;
      logic [5:0] dt[2];
      #1;
      emp[0] = vc0_empty; emp[1] = vc1_empty;
      dt[0] = vc0_data; dt[1] = vc1_data;
      for (int i = 0; i < 2; i++)
         el[i] = (!emp[i] &&
                  !(dt[i][4] ? d1_almost_full : d0_almost_full)) ? 1 : 0;
      g = -1;
      if (!reset && !init) begin
         if (m_owner < 0) begin
            if (el[0] && el[1]) g = 1 - m_last;
            else if (el[0]) g = 0;
            else if (el[1]) g = 1;
         end else if (!(emp[0] && emp[1])) begin
            x = m_owner; o = 1 - x;
            if (el[x] && m_used < m_w[x]) g = x;
            else if (el[o]) g = o;
            else if (el[x]) g = x;
         end
      end
      chk("pop_vc0", int'(pop_vc0), (g == 0) ? 1 : 0);
      chk("pop_vc1", int'(pop_vc1), (g == 1) ? 1 : 0);
      chk("push_d0", int'(push_d0), m_push0);
      chk("push_d1", int'(push_d1), m_push1);
      chk("data_out", int'(data_out), m_data);
      chk("arb_active", int'(arb_active), (m_owner >= 0) ? 1 : 0);
`ifdef ARB_STATS_EN
      chk("grant_cnt_vc0", int'(grant_cnt_vc0), m_cnt[0]);
      chk("grant_cnt_vc1", int'(grant_cnt_vc1), m_cnt[1]);
`endif
      obs_g = pop_vc0 ? 0 : (pop_vc1 ? 1 : -1);
      if (reset) begin
         model_reset();
      end else begin
         m_push0 = (g >= 0 && dt[g][4] == 1'b0) ? 1 : 0;
         m_push1 = (g >= 0 && dt[g][4] == 1'b1) ? 1 : 0;
         if (g >= 0) begin
            m_data = int'(dt[g]);
            m_last = g;
            if (m_cnt[g] < 255) m_cnt[g]++;
         end
         if (init) begin
            m_w[0] = (weight_vc0 == 0) ? 1 : int'(weight_vc0);
            m_w[1] = (weight_vc1 == 0) ? 1 : int'(weight_vc1);
            m_owner = -1; m_used = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
         end else if (g >= 0) begin
            if (g == m_owner && m_used < m_w[g]) m_used++;
            else begin
               m_owner = g; m_used = 1;
            end
         end else if (m_owner >= 0 && emp[0] && emp[1]) begin
            m_owner = -1; m_used = 0;
         end
      end
   endtask

   initial begin
      int pat_a[3];
      int pat_b[6];
      pat_a = '{0, 0, 1};
      pat_b = '{0, 1, 1, 1, 1, 0};

      tbl[0]  = '{1,0,0,0,1,1,6'h01,6'h02,0,0, 0,0,0,0,0};
      tbl[1]  = '{0,1,2,1,0,0,6'h01,6'h02,0,0, 0,0,0,0,0};
      tbl[2]  = '{0,0,0,0,0,0,6'h03,6'h04,0,0, 1,0,0,0,0};
      tbl[3]  = '{0,0,0,0,0,0,6'h05,6'h06,0,0, 1,0,1,0,1};
      tbl[4]  = '{0,0,0,0,0,0,6'h07,6'h08,0,0, 0,1,1,0,1};
      tbl[5]  = '{0,0,0,0,0,0,6'h09,6'h0a,0,0, 1,0,1,0,1};
      tbl[6]  = '{0,0,0,0,0,0,6'h0b,6'h0c,0,0, 1,0,1,0,1};
      tbl[7]  = '{0,0,0,0,0,0,6'h0d,6'h0e,0,0, 0,1,1,0,1};
      tbl[8]  = '{0,0,0,0,0,0,6'h12,6'h0f,0,1, 0,1,1,0,1};
      tbl[9]  = '{0,0,0,0,0,0,6'h12,6'h0e,0,1, 0,1,1,0,1};
      tbl[10] = '{0,0,0,0,0,0,6'h12,6'h0d,0,0, 1,0,1,0,1};
      tbl[11] = '{0,0,0,0,0,0,6'h13,6'h0c,0,0, 1,0,0,1,1};
      tbl[12] = '{0,0,0,0,1,1,6'h00,6'h00,0,0, 0,0,0,1,1};
      tbl[13] = '{0,0,0,0,1,1,6'h00,6'h00,0,0, 0,0,0,0,0};
      tbl[14] = '{0,0,0,0,1,0,6'h00,6'h05,0,0, 0,1,0,0,0};
      tbl[15] = '{0,0,0,0,1,1,6'h00,6'h00,0,0, 0,0,1,0,1};
      tbl[16] = '{0,0,0,0,1,1,6'h00,6'h00,0,0, 0,0,0,0,0};

      drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rst, tbl[i].ini, tbl[i].w0, tbl[i].w1,
               tbl[i].em0, tbl[i].em1, tbl[i].dt0, tbl[i].dt1,
               tbl[i].af0, tbl[i].af1);
         eval();
         chk($sformatf("tbl%0d_pop0", i), int'(pop_vc0), int'(tbl[i].p0));
         chk($sformatf("tbl%0d_pop1", i), int'(pop_vc1), int'(tbl[i].p1));
         chk($sformatf("tbl%0d_push0", i), int'(push_d0), int'(tbl[i].q0));
         chk($sformatf("tbl%0d_push1", i), int'(push_d1), int'(tbl[i].q1));
         chk($sformatf("tbl%0d_act", i), int'(arb_active), int'(tbl[i].act));
         tick();
      end

      // Reset mid-burst with weights 3/3 restores the 2/1 defaults
      drive(0, 1, 3, 3, 0, 0, 1, 2, 0, 0);
      eval(); tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, $urandom & 6'h2f, $urandom & 6'h2f, 0, 0);
         eval(); tick();
      end
      drive(1, 0, 0, 0, 0, 0, 3, 4, 0, 0);
      eval();
      chk("rst_pop", obs_g, -1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, $urandom & 6'h2f, $urandom & 6'h2f, 0, 0);
         eval();
         if (i == 0) begin
            chk("rst_push0", int'(push_d0), 0);
            chk("rst_push1", int'(push_d1), 0);
            chk("rst_data", int'(data_out), 0);
         end
         chk($sformatf("rst_pat%0d", i), obs_g, pat_a[i]);
         tick();
      end

      // Zero weight is treated as one
      drive(0, 1, 0, 4, 0, 0, 1, 2, 0, 0);
      eval(); tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 0, 0, 0, $urandom & 6'h2f, $urandom & 6'h2f, 0, 0);
         eval();
         chk($sformatf("w04_pat%0d", i), obs_g, pat_b[i]);
         tick();
      end

`ifdef ARB_STATS_EN
      drive(0, 1, 2, 1, 1, 1, 0, 0, 0, 0);
      eval(); tick();
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 0, 0, 0, 1, $urandom, 0, 0, 0);
         eval(); tick();
      end
      drive(0, 1, 2, 1, 1, 1, 0, 0, 0, 0);
      eval();
      chk("cnt_sat", int'(grant_cnt_vc0), 255);
      tick();
      drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      eval();
      chk("cnt_clr0", int'(grant_cnt_vc0), 0);
      chk("cnt_clr1", int'(grant_cnt_vc1), 0);
      tick();
`endif

      for (int i = 0; i < 3000; i++) begin
         bit r, n;
         r = ($urandom % 300) == 0;
         n = !r && (($urandom % 60) == 0);
         drive(r, n, $urandom % 8, $urandom % 8,
               ($urandom % 4) == 0, ($urandom % 4) == 0,
               $urandom, $urandom,
               ($urandom % 5) == 0, ($urandom % 5) == 0);
         eval();
         chk("never_both_pop", int'(pop_vc0 && pop_vc1), 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
